// File: rtl/pwm_frame_scheduler.sv
// pwm_frame_scheduler: snapshots a flattened duty bus and shifts it MSB-first
// to an external PWM driver over a data/clock/latch serial link, then pulses
// latch. Frames launch on request (start), from a pending request, or
// periodically when auto_en is set.
//
// Handshake: start is a level-sampled request with no acknowledge. In IDLE
// it launches a frame. While a frame is in flight it sets a one-deep pending
// flag, and several starts fold into that one flag. busy marks the frame in
// flight, and frame_done pulses for one cycle when the frame completes.
module pwm_frame_scheduler #(
    parameter int CHANNELS     = 4,
    parameter int DUTY_W       = 8,
    parameter int HALF_DIV     = 25,
    parameter int FRAME_CYCLES = 500000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*DUTY_W-1:0]   duty_in,
    input  logic                         start,
    input  logic                         auto_en,
    output logic                         ser_data,
    output logic                         ser_clk,
    output logic                         ser_latch,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int NBITS = CHANNELS * DUTY_W;
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int DW    = $clog2(2 * HALF_DIV);
    localparam int TW    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF_DIV - 1);
    localparam logic [DW-1:0] BIT_END   = DW'(2 * HALF_DIV - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_next;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic [TW-1:0]    timer;
    logic             pending;
    logic             launch;

    // A frame may only begin from IDLE. A pending request and an expired
    // timer fold into the same launch, so they produce a single frame.
    assign launch     = (state == IDLE) &&
                        (start || pending || (auto_en && (timer >= TIMER_MAX)));
    assign shreg_next = shreg << 1;

    // Frame sequencer: snapshot, bit shifting, latch pulse, completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            pending    <= 1'b0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        shreg    <= duty_in;
                        ser_data <= duty_in[NBITS-1];
                        ser_clk  <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        pending  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (start) pending <= 1'b1;
                    if (div_cnt == HALF_LAST) ser_clk <= 1'b1;
                    if (div_cnt == BIT_END) begin
                        div_cnt <= '0;
                        ser_clk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= shreg_next;
                            ser_data <= shreg_next[NBITS-1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (start) pending <= 1'b1;
                    if (div_cnt == HALF_LAST) begin
                        div_cnt    <= '0;
                        ser_latch  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Auto-mode frame timer: saturates at the period and restarts on every launch.
    always_ff @(posedge clock) begin
        if (reset || !auto_en || launch) begin
            timer <= '0;
        end else if (timer < TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Directed bench for pwm_frame_scheduler (2 channels x 4 bits, half bit = 2
// cycles, auto period = 100 cycles). It checks the outputs on every cycle
// against waveforms built from hand-picked duty words.
module tb_pwm_frame_scheduler;

    localparam int CH        = 2;
    localparam int DWID      = 4;
    localparam int HD        = 2;
    localparam int FC        = 100;
    localparam int NB        = CH * DWID;
    localparam int FRAME_LEN = 2 * NB * HD + HD + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] duty_in = '0;
    logic          start = 1'b0;
    logic          auto_en = 1'b0;
    logic          ser_data, ser_clk, ser_latch, busy, frame_done;

    int tests = 0;
    int fails = 0;

    pwm_frame_scheduler #(
        .CHANNELS(CH), .DUTY_W(DWID), .HALF_DIV(HD), .FRAME_CYCLES(FC)
    ) dut (
        .clock(clock), .reset(reset), .duty_in(duty_in), .start(start),
        .auto_en(auto_en), .ser_data(ser_data), .ser_clk(ser_clk),
        .ser_latch(ser_latch), .busy(busy), .frame_done(frame_done)
    );

    // Clock generation: 10 time-unit period.
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just past the active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Idle cycles with no frame activity. Outputs are {data,clk,latch,busy,done}.
    task automatic idle_cycles(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            step();
            chk($sformatf("%s_i%0d", name, i),
                {ser_data, ser_clk, ser_latch, busy, frame_done}, 5'b00000);
        end
    endtask

    // Checks one full frame. The caller sits in the launch cycle.
    // start_at pulses start at that frame cycle, hold_start keeps start high,
    // and poke_at changes duty_in mid-frame.
    task automatic run_frame(input logic [NB-1:0] exp, input int start_at,
                             input bit hold_start, input int poke_at,
                             input logic [NB-1:0] poke_val, input string name);
        logic [4:0] e;
        for (int i = 1; i <= FRAME_LEN; i++) begin
            step();
            start = hold_start || (i == start_at);
            if (i == poke_at) duty_in = poke_val;
            if (i <= 2 * NB * HD) begin
                int k;
                int ph;
                k  = (i - 1) / (2 * HD);
                ph = (i - 1) % (2 * HD);
                e  = {exp[NB-1-k], (ph >= HD), 1'b0, 1'b1, 1'b0};
            end else if (i <= 2 * NB * HD + HD) begin
                e = 5'b00110;
            end else begin
                e = 5'b00001;
            end
            chk($sformatf("%s_c%0d", name, i),
                {ser_data, ser_clk, ser_latch, busy, frame_done}, {27'b0, e});
        end
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {ser_data, ser_clk, ser_latch, busy, frame_done}, 5'b00000);
        reset = 1'b0;
        idle_cycles(10, "idle0");

        // Frame A5. duty_in changes at frame cycle 2 and start arrives mid-frame.
        duty_in = 8'hA5;
        start   = 1'b1;
        run_frame(8'hA5, 10, 1'b0, 2, 8'h3C, "f_a5");
        // The pending request launches in the completion cycle and carries the new word.
        run_frame(8'h3C, 0, 1'b0, 0, 8'h00, "f_3c");
        idle_cycles(20, "after_pending");

        // A held start gives back-to-back frames.
        duty_in = 8'h5A;
        start   = 1'b1;
        run_frame(8'h5A, 0, 1'b1, 0, 8'h00, "hold1");
        run_frame(8'h5A, 0, 1'b0, 0, 8'h00, "hold2");
        idle_cycles(10, "after_hold");

        // Reset mid-frame aborts the frame with no latch and no done pulse.
        duty_in = 8'hFF;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        chk("mid_frame_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        chk("reset_mid", {ser_data, ser_clk, ser_latch, busy, frame_done}, 5'b00000);
        reset = 1'b0;
        idle_cycles(10, "post_reset");
        duty_in = 8'hC3;
        start   = 1'b1;
        run_frame(8'hC3, 0, 1'b0, 0, 8'h00, "clean");
        idle_cycles(5, "after_clean");

        // Auto mode: the timer starts at 0 in cycle 0 and launches at cycle 99.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        auto_en = 1'b1;
        duty_in = 8'h96;
        idle_cycles(FC - 1, "auto_w1");
        run_frame(8'h96, 0, 1'b0, 0, 8'h00, "auto1");
        idle_cycles(FC - FRAME_LEN, "auto_w2");
        run_frame(8'h96, 0, 1'b0, 0, 8'h00, "auto2");
        idle_cycles(FC - FRAME_LEN, "auto_w3");

        // start and timer expiry in the same cycle produce one frame, then the timer restarts.
        start = 1'b1;
        run_frame(8'h96, 0, 1'b0, 0, 8'h00, "both");
        idle_cycles(FC - FRAME_LEN, "both_wait");
        run_frame(8'h96, 0, 1'b0, 0, 8'h00, "auto4");

        // With auto mode off, no further frames launch.
        auto_en = 1'b0;
        idle_cycles(2 * FC, "auto_off");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
